// File: rtl/dcd_q_pkg.sv
// Shared types and constants for the decode-to-allocation instruction queue.
package dcd_q_pkg;

    localparam int INST_W  = 66;
    localparam int ISSUE_W = 4;

    typedef logic [INST_W-1:0] dcd_inst_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dcd_inst_queue_if.sv
// Decode-side push bus and allocation-side pop bus of the instruction queue.
interface dcd_inst_queue_if;
    import dcd_q_pkg::*;

    dcd_inst_t  dcd_inst1_in, dcd_inst2_in, dcd_inst3_in, dcd_inst4_in;
    logic [2:0] dcd_cnt_in;
    logic       mis_pred;
    logic [2:0] al_take;
    dcd_inst_t  al_inst1_out, al_inst2_out, al_inst3_out, al_inst4_out;
    logic [2:0] al_cnt_out;
    logic       stall_dcd_out;
    logic       ovf_err;

    modport master (
        output dcd_inst1_in, dcd_inst2_in, dcd_inst3_in, dcd_inst4_in,
        output dcd_cnt_in, mis_pred, al_take,
        input  al_inst1_out, al_inst2_out, al_inst3_out, al_inst4_out,
        input  al_cnt_out, stall_dcd_out, ovf_err
    );

    modport slave (
        input  dcd_inst1_in, dcd_inst2_in, dcd_inst3_in, dcd_inst4_in,
        input  dcd_cnt_in, mis_pred, al_take,
        output al_inst1_out, al_inst2_out, al_inst3_out, al_inst4_out,
        output al_cnt_out, stall_dcd_out, ovf_err
    );

endinterface

// File: rtl/dcd_q_ptr.sv
// Head/tail/count bookkeeping, take clamp, flush, stall and overflow for the queue.
// DCD_Q_BYPASS_EN: when empty, the incoming group is visible to allocation this cycle.
module dcd_q_ptr
    import dcd_q_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PW    = clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    i_dcd_cnt,
    input  logic [2:0]    i_al_take,
    input  logic          i_mis_pred,
    output logic [PW-1:0] o_head,
    output logic [PW-1:0] o_tail,
    output logic [2:0]    o_al_cnt,
    output logic [2:0]    o_wr_skip,
    output logic          o_wr_en,
    output logic          o_bypass,
    output logic          o_stall,
    output logic          o_ovf_err
);

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [CW-1:0] w_free;
    logic [2:0]    w_q_cnt, w_al_cnt, w_take, w_skip, w_push_n, w_pop_n;
    logic          w_push_ok, w_bypass, w_take_ovf;

    // Push check uses the registered count only; a same-cycle pop is not credited.
    always_comb begin
        w_free    = CW'(DEPTH) - r_count;
        w_q_cnt   = (r_count > CW'(ISSUE_W)) ? 3'(ISSUE_W) : r_count[2:0];
        w_push_ok = (i_dcd_cnt <= 3'(ISSUE_W)) && (CW'(i_dcd_cnt) <= w_free);
        w_bypass  = 1'b0;
`ifdef DCD_Q_BYPASS_EN
        w_bypass  = (r_count == '0) && !i_mis_pred;
`endif
        w_al_cnt   = w_bypass ? (w_push_ok ? i_dcd_cnt : 3'd0) : w_q_cnt;
        w_take_ovf = i_al_take > w_al_cnt;
        w_take     = w_take_ovf ? w_al_cnt : i_al_take;
        w_skip     = w_bypass ? w_take : 3'd0;
        w_push_n   = w_push_ok ? (i_dcd_cnt - w_skip) : 3'd0;
        w_pop_n    = w_bypass ? 3'd0 : w_take;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_mis_pred) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
            r_ovf   <= w_take_ovf || !w_push_ok;
        end
    end

    assign o_head    = r_head;
    assign o_tail    = r_tail;
    assign o_al_cnt  = w_al_cnt;
    assign o_wr_skip = w_skip;
    assign o_wr_en   = w_push_ok && !i_mis_pred;
    assign o_bypass  = w_bypass;
    assign o_stall   = w_free < CW'(ISSUE_W);
    assign o_ovf_err = r_ovf;

endmodule

// File: rtl/dcd_inst_queue.sv
// Decode-to-allocation circular instruction queue: storage array and output muxing.
// DCD_Q_BYPASS_EN: empty-queue bypass from decode inputs straight to allocation outputs.
module dcd_inst_queue
    import dcd_q_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    dcd_inst_queue_if.slave  q
);

    dcd_inst_t     r_mem [DEPTH];

    dcd_inst_t     w_in    [ISSUE_W];
    dcd_inst_t     w_out   [ISSUE_W];
    logic [PW-1:0] w_waddr [ISSUE_W];
    logic          w_wsel  [ISSUE_W];
    logic [PW-1:0] w_head, w_tail;
    logic [2:0]    w_al_cnt, w_skip;
    logic          w_wr_en, w_bypass;

    dcd_q_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_dcd_cnt  (q.dcd_cnt_in),
        .i_al_take  (q.al_take),
        .i_mis_pred (q.mis_pred),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_al_cnt   (w_al_cnt),
        .o_wr_skip  (w_skip),
        .o_wr_en    (w_wr_en),
        .o_bypass   (w_bypass),
        .o_stall    (q.stall_dcd_out),
        .o_ovf_err  (q.ovf_err)
    );

    assign w_in[0] = q.dcd_inst1_in;
    assign w_in[1] = q.dcd_inst2_in;
    assign w_in[2] = q.dcd_inst3_in;
    assign w_in[3] = q.dcd_inst4_in;

    // Slots already consumed through the bypass are skipped; the rest pack from tail.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            w_wsel[k]  = w_wr_en && (3'(k) >= w_skip) && (3'(k) < q.dcd_cnt_in);
            w_waddr[k] = w_tail + PW'(k) - PW'(w_skip);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < ISSUE_W; k++) begin
            if (w_wsel[k]) r_mem[w_waddr[k]] <= w_in[k];
        end
    end

    always_comb begin
        for (int n = 0; n < ISSUE_W; n++) begin
            w_out[n] = '0;
            if (3'(n) < w_al_cnt) w_out[n] = w_bypass ? w_in[n] : r_mem[w_head + PW'(n)];
        end
    end

    assign q.al_inst1_out = w_out[0];
    assign q.al_inst2_out = w_out[1];
    assign q.al_inst3_out = w_out[2];
    assign q.al_inst4_out = w_out[3];
    assign q.al_cnt_out   = w_al_cnt;

endmodule
